// File: rtl/mem_req_bridge.sv
// rtl/mem_req_bridge.sv - core load/store request to 64-bit SRAM word bridge
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         core request handshake (ready only in IDLE)
//   req_addr/wen/size/signed    byte address, store flag, log2 size, load signedness
//   req_wdata                   right-justified store data
//   rsp_valid/rsp_ready         core response handshake
//   rsp_rdata/rsp_err           extended load data (0 for stores/errors), error flag
//   sram_en/we/addr/wdata       SRAM strobe, byte-lane enables, word address, lane data
//   sram_rdata                  SRAM read word, valid the cycle after the access
module mem_req_bridge #(
    parameter logic [63:0] MEM_BASE = 64'h8000_0000,
    parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sram_en,
    output logic [7:0]  sram_we,
    output logic [63:0] sram_addr,
    output logic [63:0] sram_wdata,
    input  logic [63:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  off_q;
    logic        wen_q;
    logic [1:0]  size_q;
    logic        signed_q;

    logic        accept;
    logic        aligned;
    logic        in_range;
    logic        legal;
    logic [3:0]  nbytes;
    logic [64:0] req_end;
    logic [64:0] mem_end;
    logic [7:0]  base_mask;
    logic [63:0] shifted;
    logic [63:0] load_val;

    // Legality is decided on the live request so an illegal one goes straight to RESP.
    always_comb begin
        nbytes   = 4'd1 << req_size;
        aligned  = 1'b1;
        case (req_size)
            2'd1:    aligned = (req_addr[0]   == 1'b0);
            2'd2:    aligned = (req_addr[1:0] == 2'b00);
            2'd3:    aligned = (req_addr[2:0] == 3'b000);
            default: aligned = 1'b1;
        endcase
        // 65-bit arithmetic so an address near 2^64 cannot wrap into range.
        req_end  = {1'b0, req_addr} + {61'b0, nbytes};
        mem_end  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
        in_range = ({1'b0, req_addr} >= {1'b0, MEM_BASE}) && (req_end <= mem_end);
        legal    = aligned && in_range;
        accept   = req_valid && (state == IDLE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = legal ? ISSUE : RESP;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        case (size_q)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        // Gated by rst_n directly so a reset landing mid-ISSUE never writes.
        sram_en = rst_n && (state == ISSUE);
        sram_we = (sram_en && wen_q) ? (base_mask << off_q) : 8'h00;
    end

    always_comb begin
        shifted = sram_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_val = {{56{signed_q & shifted[7]}},  shifted[7:0]};
            2'd1:    load_val = {{48{signed_q & shifted[15]}}, shifted[15:0]};
            2'd2:    load_val = {{32{signed_q & shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            off_q      <= 3'd0;
            wen_q      <= 1'b0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
            sram_addr  <= 64'd0;
            sram_wdata <= 64'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                off_q     <= req_addr[2:0];
                wen_q     <= req_wen;
                size_q    <= req_size;
                signed_q  <= req_signed;
                rsp_rdata <= 64'd0;
                rsp_err   <= ~legal;
                // SRAM-facing address/data only move for requests that will reach the SRAM.
                if (legal) begin
                    sram_addr  <= {req_addr[63:3], 3'b000};
                    sram_wdata <= req_wdata << {req_addr[2:0], 3'b000};
                end
            end
            if (state == WAIT) begin
                rsp_rdata <= wen_q ? 64'd0 : load_val;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule
